// File: rtl/johnson_pkg.sv
// -----------------------------------------------------------------------------
// johnson_pkg
// Shared definitions for the Johnson counter controller:
//   op_e              command opcodes carried on cmd_op
//   state_e           controller FSM state encoding
//   is_legal_johnson  checks that a value is one of the 2*WIDTH Johnson states
// -----------------------------------------------------------------------------
package johnson_pkg;

  // Widest register the legality check can inspect.
  localparam int MAX_JW = 32;

  typedef enum logic [1:0] {
    OP_STEP  = 2'b00,
    OP_LOAD  = 2'b01,
    OP_CLEAR = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // A Johnson value has at most one boundary between a run of ones and a run
  // of zeros among its low 'width' bits.
  function automatic logic is_legal_johnson(input logic [MAX_JW-1:0] value,
                                            input int width);
    int n;
    n = 0;
    for (int i = 0; i < MAX_JW - 1; i++) begin
      if ((i < width - 1) && (value[i] != value[i+1])) n++;
    end
    return (n <= 1);
  endfunction

endpackage

// File: rtl/johnson_controller_if.sv
// -----------------------------------------------------------------------------
// johnson_controller_if
// Command and status bundle between a control master and johnson_controller.
//   cmd_valid/cmd_ready  command handshake
//   cmd_op/dir/steps/value  command payload
//   hold                 freezes a running STEP
//   out/busy/done/err    counter value and status
// master: drives commands; slave: the controller.
// -----------------------------------------------------------------------------
interface johnson_controller_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_steps;
  logic [WIDTH-1:0] cmd_value;
  logic             hold;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output cmd_valid, cmd_op, cmd_dir, cmd_steps, cmd_value, hold,
    input  cmd_ready, out, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dir, cmd_steps, cmd_value, hold,
    output cmd_ready, out, busy, done, err
  );
endinterface

// File: rtl/johnson_core.sv
// -----------------------------------------------------------------------------
// johnson_core
// WIDTH-bit Johnson shift register.
//   clk, rst        clock, asynchronous active-low reset (register -> 0)
//   en_i, dir_i     shift one position; dir_i 0 forward, 1 reverse
//   load_i          load load_value_i (has priority over en_i)
//   load_value_i    value to load
//   out_o           current register value
// -----------------------------------------------------------------------------
module johnson_core
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic [WIDTH-1:0] out_o
);

  logic [WIDTH-1:0] jc_q;
  logic [WIDTH-1:0] jc_d;

  always_comb begin
    jc_d = jc_q;
    if (load_i) begin
      jc_d = load_value_i;
    end else if (en_i) begin
      // Forward feeds the inverted MSB into the LSB; reverse mirrors it.
      jc_d = dir_i ? {~jc_q[0], jc_q[WIDTH-1:1]}
                   : {jc_q[WIDTH-2:0], ~jc_q[WIDTH-1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) jc_q <= '0;
    else      jc_q <= jc_d;
  end

  assign out_o = jc_q;

endmodule

// File: rtl/johnson_controller.sv
// -----------------------------------------------------------------------------
// johnson_controller
// Command sequencer for a Johnson counter: runs STEP commands for a programmed
// number of cycles in either direction (pausable via hold), loads legal
// Johnson values, clears, and flags illegal loads / reserved opcodes.
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   johnson_controller_if slave: command handshake, hold, out/busy/done/err
// -----------------------------------------------------------------------------
module johnson_controller
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  johnson_controller_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             err_q, err_d;
  logic             dir_q, dir_d;

  logic             core_en;
  logic             core_load;
  logic [WIDTH-1:0] core_value;
  logic [WIDTH-1:0] core_out;
  op_e              op;
  logic             value_legal;

  assign op          = op_e'(bus.cmd_op);
  assign value_legal = is_legal_johnson(MAX_JW'(bus.cmd_value), WIDTH);

  johnson_core #(.WIDTH(WIDTH)) u_core (
    .clk          (clk),
    .rst          (rst),
    .en_i         (core_en),
    .dir_i        (dir_q),
    .load_i       (core_load),
    .load_value_i (core_value),
    .out_o        (core_out)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      err_q   <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    err_d      = err_q;
    dir_d      = dir_q;
    core_en    = 1'b0;
    core_load  = 1'b0;
    core_value = '0;
    unique case (state_q)
      ST_IDLE: begin
        // cmd_ready is constant 1 here, so cmd_valid alone means accept.
        if (bus.cmd_valid) begin
          err_d   = 1'b0;
          state_d = ST_DONE;
          unique case (op)
            OP_STEP: begin
              if (bus.cmd_steps != '0) begin
                dir_d   = bus.cmd_dir;
                rem_d   = bus.cmd_steps;
                state_d = ST_RUN;
              end
            end
            OP_LOAD: begin
              // Illegal values load zero so the counter never leaves the ring.
              core_load = 1'b1;
              if (value_legal) core_value = bus.cmd_value;
              else             err_d      = 1'b1;
            end
            OP_CLEAR: core_load = 1'b1;
            default:  err_d     = 1'b1;
          endcase
        end
      end
      ST_RUN: begin
        if (!bus.hold) begin
          core_en = 1'b1;
          rem_d   = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registers only
  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.err       = err_q;
  assign bus.out       = core_out;

endmodule
